// File: rtl/eth_link_mgr.sv
// Multi-channel 10G link manager: per-channel reset sequencing, link
// qualification with retry accounting, and an aggregate all-up flag.
module eth_link_mgr #(
  parameter int P_CH_NUM       = 2,
  parameter int P_RST_CYCLE    = 20,
  parameter int P_DONE_TIMEOUT = 1000000,
  parameter int P_LINK_TIMEOUT = 1000000,
  parameter int P_STABLE_CYCLE = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [P_CH_NUM-1:0]   i_ch_en,
  input  logic [P_CH_NUM-1:0]   i_rst_done,
  input  logic [P_CH_NUM-1:0]   i_block_sync,
  input  logic [P_CH_NUM-1:0]   i_pcs_rx_link,
  output logic [P_CH_NUM-1:0]   o_gt_rst,
  output logic [P_CH_NUM-1:0]   o_mac_rst,
  output logic [P_CH_NUM-1:0]   o_link_up,
  output logic [8*P_CH_NUM-1:0] o_retry_cnt,
  output logic                  o_all_up
);

  localparam int C_MAX_TO = (P_DONE_TIMEOUT > P_LINK_TIMEOUT) ? P_DONE_TIMEOUT : P_LINK_TIMEOUT;
  localparam int C_MAX_RS = (P_RST_CYCLE > P_STABLE_CYCLE) ? P_RST_CYCLE : P_STABLE_CYCLE;
  localparam int C_MAX    = (C_MAX_TO > C_MAX_RS) ? C_MAX_TO : C_MAX_RS;
  localparam int C_CW     = $clog2(C_MAX + 1);

  localparam logic [C_CW-1:0] C_RST_LAST  = C_CW'(P_RST_CYCLE - 1);
  localparam logic [C_CW-1:0] C_DONE_LAST = C_CW'(P_DONE_TIMEOUT - 1);
  localparam logic [C_CW-1:0] C_LINK_LAST = C_CW'(P_LINK_TIMEOUT - 1);
  localparam logic [C_CW-1:0] C_STAB_LAST = C_CW'(P_STABLE_CYCLE - 1);
  localparam logic [C_CW-1:0] C_ONE       = C_CW'(1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_RST       = 3'd1;
  localparam logic [2:0] S_WAIT_DONE = 3'd2;
  localparam logic [2:0] S_WAIT_LINK = 3'd3;
  localparam logic [2:0] S_UP        = 3'd4;

  logic [P_CH_NUM-1:0] r_done_s1, r_done_s2;
  logic [P_CH_NUM-1:0] r_bs_s1,   r_bs_s2;
  logic [P_CH_NUM-1:0] r_link_s1, r_link_s2;
  logic [P_CH_NUM-1:0] w_link_up;
  logic                r_all_up;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_done_s1 <= '0;
      r_done_s2 <= '0;
      r_bs_s1   <= '0;
      r_bs_s2   <= '0;
      r_link_s1 <= '0;
      r_link_s2 <= '0;
    end else begin
      r_done_s1 <= i_rst_done;
      r_done_s2 <= r_done_s1;
      r_bs_s1   <= i_block_sync;
      r_bs_s2   <= r_bs_s1;
      r_link_s1 <= i_pcs_rx_link;
      r_link_s2 <= r_link_s1;
    end
  end

  for (genvar g = 0; g < P_CH_NUM; g++) begin : g_ch
    logic [2:0]      r_state, w_state_nxt;
    logic [C_CW-1:0] r_cnt, w_cnt_nxt;
    logic [C_CW-1:0] r_stab, w_stab_nxt;
    logic [7:0]      r_retry;
    logic            r_gt_rst, r_mac_rst, r_link_up;
    logic            w_fail;
    logic            w_done, w_good;

    assign w_done = r_done_s2[g];
    assign w_good = r_done_s2[g] & r_bs_s2[g] & r_link_s2[g];

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_stab_nxt  = r_stab;
      w_fail      = 1'b0;
      if (!i_ch_en[g]) begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_stab_nxt  = '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            w_state_nxt = S_RST;
            w_cnt_nxt   = '0;
          end
          S_RST: begin
            if (r_cnt == C_RST_LAST) begin
              w_state_nxt = S_WAIT_DONE;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = r_cnt + C_ONE;
            end
          end
          S_WAIT_DONE: begin
            if (w_done) begin
              w_state_nxt = S_WAIT_LINK;
              w_cnt_nxt   = '0;
              w_stab_nxt  = '0;
            end else if (r_cnt == C_DONE_LAST) begin
              w_state_nxt = S_RST;
              w_cnt_nxt   = '0;
              w_fail      = 1'b1;
            end else begin
              w_cnt_nxt = r_cnt + C_ONE;
            end
          end
          S_WAIT_LINK: begin
            // Losing reset-done outranks qualification; the stable count
            // wins over the total-time budget when both land together.
            if (!w_done) begin
              w_state_nxt = S_RST;
              w_cnt_nxt   = '0;
              w_fail      = 1'b1;
            end else if (w_good && (r_stab == C_STAB_LAST)) begin
              w_state_nxt = S_UP;
              w_cnt_nxt   = '0;
            end else if (r_cnt == C_LINK_LAST) begin
              w_state_nxt = S_RST;
              w_cnt_nxt   = '0;
              w_fail      = 1'b1;
            end else begin
              w_cnt_nxt  = r_cnt + C_ONE;
              w_stab_nxt = w_good ? (r_stab + C_ONE) : '0;
            end
          end
          S_UP: begin
            if (!w_good) begin
              w_state_nxt = S_RST;
              w_cnt_nxt   = '0;
              w_fail      = 1'b1;
            end
          end
          default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_stab_nxt  = '0;
          end
        endcase
      end
    end

    // Outputs decode the next state so they align with the state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_state   <= S_IDLE;
        r_cnt     <= '0;
        r_stab    <= '0;
        r_retry   <= '0;
        r_gt_rst  <= 1'b1;
        r_mac_rst <= 1'b1;
        r_link_up <= 1'b0;
      end else begin
        r_state   <= w_state_nxt;
        r_cnt     <= w_cnt_nxt;
        r_stab    <= w_stab_nxt;
        if (w_fail && (r_retry != 8'hFF)) r_retry <= r_retry + 8'd1;
        r_gt_rst  <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_RST);
        r_mac_rst <= (w_state_nxt != S_UP);
        r_link_up <= (w_state_nxt == S_UP);
      end
    end

    assign o_gt_rst[g]          = r_gt_rst;
    assign o_mac_rst[g]         = r_mac_rst;
    assign w_link_up[g]         = r_link_up;
    assign o_retry_cnt[8*g +: 8] = r_retry;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_all_up <= 1'b0;
    else       r_all_up <= (|i_ch_en) & (&(w_link_up | ~i_ch_en));
  end

  assign o_link_up = w_link_up;
  assign o_all_up  = r_all_up;

endmodule

// File: tb/tb_eth_link_mgr.sv
// Bench for eth_link_mgr: table-driven bring-up, directed corner sequences,
// and randomized traffic against a phase/elapsed-time reference model.
module tb_eth_link_mgr;

  localparam int P_RST  = 4;
  localparam int P_DONE = 50;
  localparam int P_LINK = 60;
  localparam int P_STAB = 8;

  logic        clk, rst;
  logic [1:0]  ch_en, done, bs, link;
  logic [1:0]  o_gt_rst, o_mac_rst, o_link_up;
  logic [15:0] o_retry_cnt;
  logic        o_all_up;

  int n_pass  = 0;
  int n_total = 0;

  eth_link_mgr #(
    .P_CH_NUM(2), .P_RST_CYCLE(P_RST), .P_DONE_TIMEOUT(P_DONE),
    .P_LINK_TIMEOUT(P_LINK), .P_STABLE_CYCLE(P_STAB)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_ch_en(ch_en), .i_rst_done(done),
    .i_block_sync(bs), .i_pcs_rx_link(link), .o_gt_rst(o_gt_rst),
    .o_mac_rst(o_mac_rst), .o_link_up(o_link_up), .o_retry_cnt(o_retry_cnt),
    .o_all_up(o_all_up)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset(input logic [1:0] en, input logic [1:0] d,
                             input logic [1:0] b, input logic [1:0] l);
    rst = 1'b1; ch_en = en; done = d; bs = b; link = l;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Reference model: each channel is a phase plus time-in-phase and run length.
  typedef enum int {M_OFF, M_PULSE, M_AWAIT_DONE, M_QUALIFY, M_LINKED} phase_t;
  phase_t     m_ph[2];
  int         m_el[2], m_run[2], m_retry[2];
  logic [1:0] m_d1_done, m_d2_done, m_d1_bs, m_d2_bs, m_d1_link, m_d2_link;
  logic       m_all;

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_ph[c] = M_OFF; m_el[c] = 0; m_run[c] = 0; m_retry[c] = 0;
    end
    m_d1_done = 0; m_d2_done = 0; m_d1_bs = 0; m_d2_bs = 0;
    m_d1_link = 0; m_d2_link = 0; m_all = 0;
  endtask

  function automatic logic [1:0] model_up();
    logic [1:0] u;
    for (int c = 0; c < 2; c++) u[c] = (m_ph[c] == M_LINKED);
    return u;
  endfunction

  task automatic model_step();
    logic [1:0] up_prev;
    logic       dn, good, fail;
    up_prev = model_up();
    m_all = (ch_en != 2'b00) && ((up_prev | ~ch_en) == 2'b11);
    for (int c = 0; c < 2; c++) begin
      dn   = m_d2_done[c];
      good = m_d2_done[c] & m_d2_bs[c] & m_d2_link[c];
      fail = 1'b0;
      if (!ch_en[c]) begin
        m_ph[c] = M_OFF; m_el[c] = 0; m_run[c] = 0;
      end else begin
        case (m_ph[c])
          M_OFF: begin m_ph[c] = M_PULSE; m_el[c] = 0; end
          M_PULSE: begin
            m_el[c]++;
            if (m_el[c] == P_RST) begin m_ph[c] = M_AWAIT_DONE; m_el[c] = 0; end
          end
          M_AWAIT_DONE: begin
            m_el[c]++;
            if (dn) begin m_ph[c] = M_QUALIFY; m_el[c] = 0; m_run[c] = 0; end
            else if (m_el[c] == P_DONE) fail = 1'b1;
          end
          M_QUALIFY: begin
            m_el[c]++;
            if (!dn) fail = 1'b1;
            else begin
              m_run[c] = good ? m_run[c] + 1 : 0;
              if (m_run[c] == P_STAB) m_ph[c] = M_LINKED;
              else if (m_el[c] == P_LINK) fail = 1'b1;
            end
          end
          default: if (!good) fail = 1'b1;
        endcase
        if (fail) begin
          m_ph[c] = M_PULSE; m_el[c] = 0;
          if (m_retry[c] < 255) m_retry[c]++;
        end
      end
    end
    m_d2_done = m_d1_done; m_d1_done = done;
    m_d2_bs   = m_d1_bs;   m_d1_bs   = bs;
    m_d2_link = m_d1_link; m_d1_link = link;
  endtask

  function automatic logic [22:0] model_pack();
    logic [1:0] gt, mac, up;
    for (int c = 0; c < 2; c++) begin
      gt[c]  = (m_ph[c] == M_OFF) || (m_ph[c] == M_PULSE);
      mac[c] = (m_ph[c] != M_LINKED);
      up[c]  = (m_ph[c] == M_LINKED);
    end
    return {gt, mac, up, m_all, 8'(m_retry[1]), 8'(m_retry[0])};
  endfunction

  typedef struct {
    logic [1:0] en, dn, b, l;
    int         ticks;
    logic [1:0] gt, mac, up;
    logic       all;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int rand_fail;
    rst = 1'b1; ch_en = 0; done = 0; bs = 0; link = 0;

    // Bring-up of channel 0: done arrives 10 cycles after release.
    tbl[0] = '{2'b01, 2'b00, 2'b01, 2'b01, 1, 2'b11, 2'b11, 2'b00, 1'b0};
    tbl[1] = '{2'b01, 2'b00, 2'b01, 2'b01, 3, 2'b11, 2'b11, 2'b00, 1'b0};
    tbl[2] = '{2'b01, 2'b00, 2'b01, 2'b01, 1, 2'b10, 2'b11, 2'b00, 1'b0};
    tbl[3] = '{2'b01, 2'b00, 2'b01, 2'b01, 5, 2'b10, 2'b11, 2'b00, 1'b0};
    tbl[4] = '{2'b01, 2'b01, 2'b01, 2'b01, 3, 2'b10, 2'b11, 2'b00, 1'b0};
    tbl[5] = '{2'b01, 2'b01, 2'b01, 2'b01, 7, 2'b10, 2'b11, 2'b00, 1'b0};
    tbl[6] = '{2'b01, 2'b01, 2'b01, 2'b01, 1, 2'b10, 2'b10, 2'b01, 1'b0};
    tbl[7] = '{2'b01, 2'b01, 2'b01, 2'b01, 1, 2'b10, 2'b10, 2'b01, 1'b1};

    @(negedge clk);
    check("rst gt_rst",  32'(o_gt_rst),    3);
    check("rst mac_rst", 32'(o_mac_rst),   3);
    check("rst link_up", 32'(o_link_up),   0);
    check("rst retry",   32'(o_retry_cnt), 0);
    check("rst all_up",  32'(o_all_up),    0);

    apply_reset(2'b01, 2'b00, 2'b01, 2'b01);
    for (int i = 0; i < 8; i++) begin
      ch_en = tbl[i].en; done = tbl[i].dn; bs = tbl[i].b; link = tbl[i].l;
      tick(tbl[i].ticks);
      check($sformatf("vec%0d gt_rst", i),  32'(o_gt_rst),    32'(tbl[i].gt));
      check($sformatf("vec%0d mac_rst", i), 32'(o_mac_rst),   32'(tbl[i].mac));
      check($sformatf("vec%0d link_up", i), 32'(o_link_up),   32'(tbl[i].up));
      check($sformatf("vec%0d all_up", i),  32'(o_all_up),    32'(tbl[i].all));
      check($sformatf("vec%0d retry", i),   32'(o_retry_cnt), 0);
    end

    // Glitch: block_sync seen low by the FSM on the 6th qualifying cycle.
    apply_reset(2'b01, 2'b01, 2'b01, 2'b01);
    tick(9);  bs = 2'b00;
    tick(1);  bs = 2'b01;
    tick(4);  check("glitch restart", 32'(o_link_up[0]), 0);
    tick(5);  check("glitch pre-up",  32'(o_link_up[0]), 0);
    tick(1);  check("glitch up",      32'(o_link_up[0]), 1);

    // Link loss from S_UP.
    link = 2'b00;
    tick(2);  check("loss sync delay", 32'(o_link_up[0]), 1);
    tick(1);
    check("loss link_up", 32'(o_link_up[0]),      0);
    check("loss mac_rst", 32'(o_mac_rst[0]),      1);
    check("loss gt_rst",  32'(o_gt_rst[0]),       1);
    check("loss retry",   32'(o_retry_cnt[7:0]),  1);
    link = 2'b01;
    tick(1);  check("loss all_up", 32'(o_all_up), 0);
    for (int i = 0; i < 200 && !o_link_up[0]; i++) tick(1);
    check("relink", 32'(o_link_up[0]), 1);

    // Disable from S_UP.
    ch_en = 2'b00;
    tick(1);
    check("dis link_up", 32'(o_link_up),        0);
    check("dis gt_rst",  32'(o_gt_rst),         3);
    check("dis all_up",  32'(o_all_up),         0);
    check("dis retry",   32'(o_retry_cnt[7:0]), 1);

    // Asynchronous reset while in S_WAIT_LINK.
    ch_en = 2'b01;
    tick(8);  check("pre-rst in wait_link", 32'(o_link_up[0]), 0);
    rst = 1'b1;
    #1;
    check("async gt_rst",  32'(o_gt_rst),    3);
    check("async mac_rst", 32'(o_mac_rst),   3);
    check("async link_up", 32'(o_link_up),   0);
    check("async retry",   32'(o_retry_cnt), 0);
    check("async all_up",  32'(o_all_up),    0);
    @(negedge clk);
    rst = 1'b0;
    tick(13); check("restart pre-up", 32'(o_link_up[0]), 0);
    tick(1);  check("restart up",     32'(o_link_up[0]), 1);

    // Done timeout: 54-cycle retry period, then saturation.
    apply_reset(2'b01, 2'b00, 2'b01, 2'b01);
    tick(54); check("to gt low",   32'(o_gt_rst[0]), 0);
              check("to retry0",   32'(o_retry_cnt[7:0]), 0);
    tick(1);  check("to gt pulse", 32'(o_gt_rst[0]), 1);
              check("to retry1",   32'(o_retry_cnt[7:0]), 1);
    tick(3);  check("to gt width", 32'(o_gt_rst[0]), 1);
    tick(1);  check("to gt end",   32'(o_gt_rst[0]), 0);
    tick(49); check("to retry1 hold", 32'(o_retry_cnt[7:0]), 1);
    tick(1);  check("to retry2",   32'(o_retry_cnt[7:0]), 2);
              check("to gt pulse2", 32'(o_gt_rst[0]), 1);
    tick(54); check("to retry3",   32'(o_retry_cnt[7:0]), 3);
    tick(13770 - 163); check("sat 254", 32'(o_retry_cnt[7:0]), 254);
    tick(1);           check("sat 255", 32'(o_retry_cnt[7:0]), 255);
    tick(16210 - 13771);
    check("sat hold", 32'(o_retry_cnt[7:0]),  255);
    check("sat ch1",  32'(o_retry_cnt[15:8]), 0);
    check("sat ch1 idle", 32'(o_gt_rst[1]),   1);

    // Randomized traffic on both channels against the model.
    apply_reset(2'b11, 2'b00, 2'b00, 2'b00);
    model_reset();
    rand_fail = 0;
    for (int cyc = 0; cyc < 3000 && rand_fail < 10; cyc++) begin
      for (int c = 0; c < 2; c++) begin
        if ($urandom_range(199) == 0) ch_en[c] = ~ch_en[c];
        if (done[c]) begin if ($urandom_range(79) == 0) done[c] = 1'b0; end
        else if ($urandom_range(5) == 0) done[c] = 1'b1;
        if (bs[c]) begin if ($urandom_range(39) == 0) bs[c] = 1'b0; end
        else if ($urandom_range(3) == 0) bs[c] = 1'b1;
        if (link[c]) begin if ($urandom_range(39) == 0) link[c] = 1'b0; end
        else if ($urandom_range(3) == 0) link[c] = 1'b1;
      end
      @(posedge clk);
      model_step();
      @(negedge clk);
      if ({o_gt_rst, o_mac_rst, o_link_up, o_all_up, o_retry_cnt} !== model_pack())
        rand_fail++;
      check($sformatf("rand cyc %0d", cyc),
            32'({o_gt_rst, o_mac_rst, o_link_up, o_all_up, o_retry_cnt}),
            32'(model_pack()));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
